ym3438_fsm: RTL and testbench

- Slot sequencer directly downstream of the ym3438 prescaler.
- Consumes the two-phase internal clock enables c1/c2 and the prescaler's reset_fsm request.
- Produces the 24-cycle slot counter and its channel/operator decode, which every per-slot pipeline in the core uses to select channel and operator state.
- Runs entirely in the MCLK domain; c1/c2 are treated as level enables and edge-detected internally.

---
 rtl/ym3438_pkg.sv | 29 ++
 rtl/ym3438_edge_det.sv | 23 ++
 rtl/ym3438_fsm.sv | 100 ++++++++++
 tb/tb_ym3438_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ym3438_pkg.sv
// Shared constants, types and slot decode for the ym3438 slot sequencer.
// The group-to-operator table follows the chip's op1, op3, op2, op4 slot order.
package ym3438_pkg;

    localparam int YM_NUM_CYCLES = 24;
    localparam int YM_CH_PER_GRP = 6;

    // Operator index per group, packed LSB-first: group0->0, group1->2, group2->1, group3->3
    localparam logic [7:0] YM_OP_MAP = {2'd3, 2'd1, 2'd2, 2'd0};

    typedef logic [4:0] cycle_t;

    typedef struct packed {
        cycle_t     cycle;
        logic [2:0] ch;
        logic [1:0] op;
    } slot_t;

    function automatic slot_t slot_decode(input cycle_t c);
        slot_t s;
        int    grp;
        grp     = int'(c) / YM_CH_PER_GRP;
        s.cycle = c;
        s.ch    = 3'(int'(c) - grp * YM_CH_PER_GRP);
        s.op    = YM_OP_MAP[{grp[1:0], 1'b0} +: 2];
        return s;
    endfunction

endpackage

// File: rtl/ym3438_edge_det.sv
// Single-bit rising-edge detector in the MCLK domain.
// The pulse is combinational from the current level and its one-MCLK delayed copy.
module ym3438_edge_det (
    input  logic MCLK,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/ym3438_fsm.sv
// Slot sequencer: advances the 24-slot counter on each c2 edge, realigns on a
// latched reset_fsm request. Define YM3438_FSM_FRAME_CNT_EN to add a frame counter.
module ym3438_fsm
    import ym3438_pkg::*;
(
    input  logic       MCLK,
    input  logic       reset,
    input  logic       c1,
    input  logic       c2,
    input  logic       reset_fsm,
    output logic [4:0] cycle,
    output logic [2:0] ch,
    output logic [1:0] op,
    output logic       sync_frame,
    output logic       slot_adv
`ifdef YM3438_FSM_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam cycle_t LAST_CYCLE = cycle_t'(YM_NUM_CYCLES - 1);

    logic   e1;
    logic   e2;
    logic   rq;
    logic   rq_eff;
    logic   wrap;
    cycle_t cycle_nxt;
    slot_t  slot_nxt;

    ym3438_edge_det u_c1_edge (
        .MCLK  (MCLK),
        .reset (reset),
        .d     (c1),
        .rise  (e1)
    );

    ym3438_edge_det u_c2_edge (
        .MCLK  (MCLK),
        .reset (reset),
        .d     (c2),
        .rise  (e2)
    );

    // A coincident e1 lands its request before the e2 that consumes it.
    assign rq_eff = e1 ? reset_fsm : rq;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wrap      = 1'b0;
        cycle_nxt = cycle;
        if (rq_eff || (cycle > LAST_CYCLE)) begin
            cycle_nxt = '0;
        end else if (cycle == LAST_CYCLE) begin
            cycle_nxt = '0;
            wrap      = 1'b1;
        end else begin
            cycle_nxt = cycle + 5'd1;
        end
    end

    // Decode from the next value so cycle, ch and op update on the same MCLK.
    assign slot_nxt = slot_decode(cycle_nxt);

    always_ff @(posedge MCLK) begin
        if (reset) begin
            rq         <= 1'b0;
            cycle      <= '0;
            ch         <= '0;
            op         <= '0;
            sync_frame <= 1'b0;
            slot_adv   <= 1'b0;
        end else begin
            sync_frame <= e2 & wrap;
            slot_adv   <= e2;
            if (e1) begin
                rq <= reset_fsm;
            end
            if (e2) begin
                cycle <= slot_nxt.cycle;
                ch    <= slot_nxt.ch;
                op    <= slot_nxt.op;
            end
        end
    end

`ifdef YM3438_FSM_FRAME_CNT_EN
    always_ff @(posedge MCLK) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (e2 && rq_eff) begin
            frame_cnt <= '0;
        end else if (e2 && wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ym3438_fsm.sv
// Directed bench for ym3438_fsm: table of prescaler periods plus hand-written
// corner sequences (coincident edges, idle hold, reset with c2 held high).
module tb_ym3438_fsm;

    logic       MCLK = 1'b0;
    logic       reset;
    logic       c1;
    logic       c2;
    logic       reset_fsm;
    logic [4:0] cycle;
    logic [2:0] ch;
    logic [1:0] op;
    logic       sync_frame;
    logic       slot_adv;
`ifdef YM3438_FSM_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int adv_cnt   = 0;
    int sync_cnt  = 0;

    // Values captured at the e2 response and one MCLK later
    logic [4:0] s_cyc;
    logic [2:0] s_ch;
    logic [1:0] s_op;
    logic       s_sync, s_adv, s_sync_after, s_adv_after;

    typedef struct {
        logic rfsm;
        logic glitch;
        int   cyc;
        logic sync;
    } vec_t;

    vec_t vecs[$];

    ym3438_fsm dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .c1         (c1),
        .c2         (c2),
        .reset_fsm  (reset_fsm),
        .cycle      (cycle),
        .ch         (ch),
        .op         (op),
        .sync_frame (sync_frame),
        .slot_adv   (slot_adv)
`ifdef YM3438_FSM_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) begin
        if (slot_adv === 1'b1) adv_cnt++;
        if (sync_frame === 1'b1) sync_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    function automatic void add(input logic rfsm, input logic glitch, input int cyc, input logic sync);
        vec_t v;
        v.rfsm = rfsm; v.glitch = glitch; v.cyc = cyc; v.sync = sync;
        vecs.push_back(v);
    endfunction

    function automatic int exp_op(input int c);
        if (c < 6) return 0;
        else if (c < 12) return 2;
        else if (c < 18) return 1;
        else return 3;
    endfunction

    // One prescaler period: c1 high 2 MCLK, gap, c2 high 2 MCLK, gap.
    task automatic run_period(input logic rfsm, input logic glitch);
        c1 = 1'b1; reset_fsm = rfsm; tick();
        reset_fsm = 1'b0; tick();
        c1 = 1'b0; reset_fsm = glitch; tick();
        reset_fsm = 1'b0; c2 = 1'b1; tick();
        s_cyc = cycle; s_ch = ch; s_op = op; s_sync = sync_frame; s_adv = slot_adv;
        tick();
        s_sync_after = sync_frame; s_adv_after = slot_adv;
        c2 = 1'b0; tick();
    endtask

    initial begin
        int adv_base, sync_base;
        reset = 1'b1; c1 = 1'b0; c2 = 1'b0; reset_fsm = 1'b0;

        // Reset held with c1/c2 toggling
        for (int i = 0; i < 4; i++) begin
            c1 = i[0]; c2 = ~i[0]; reset_fsm = i[0];
            tick();
            check("rst_outs", {cycle, ch, op, sync_frame, slot_adv}, 0);
        end
        c1 = 1'b0; c2 = 1'b0; reset_fsm = 1'b0; reset = 1'b0;
        tick();
        check("post_rst_outs", {cycle, ch, op, sync_frame, slot_adv}, 0);
        tick();

        // Realign, full frame plus 5, counting to 10, realign, glitches, held rq
        add(1, 0, 0, 0);
        for (int i = 1; i <= 23; i++) add(0, 0, i, 0);
        add(0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) add(0, 0, i, 0);
        add(1, 0, 0, 0);
        add(0, 0, 1, 0);
        add(0, 0, 2, 0);
        add(0, 1, 3, 0);
        add(0, 1, 4, 0);
        add(0, 0, 5, 0);
        add(1, 0, 0, 0);
        add(1, 0, 0, 0);
        add(0, 0, 1, 0);

        adv_base = adv_cnt; sync_base = sync_cnt;
        for (int i = 0; i < vecs.size(); i++) begin
            run_period(vecs[i].rfsm, vecs[i].glitch);
            check($sformatf("cycle[%0d]", i), 32'(s_cyc), 32'(vecs[i].cyc));
            check($sformatf("ch[%0d]", i), 32'(s_ch), 32'(vecs[i].cyc % 6));
            check($sformatf("op[%0d]", i), 32'(s_op), 32'(exp_op(vecs[i].cyc)));
            check($sformatf("sync[%0d]", i), 32'(s_sync), 32'(vecs[i].sync));
            check($sformatf("adv[%0d]", i), 32'(s_adv), 1);
            check($sformatf("pulse_end[%0d]", i), {30'd0, s_sync_after, s_adv_after}, 0);
            if (vecs[i].cyc == 7) check("dec7", {29'd0, s_ch, s_op}, {29'd0, 3'd1, 2'd2});
            if (vecs[i].cyc == 13) check("dec13", {29'd0, s_ch, s_op}, {29'd0, 3'd1, 2'd1});
            if (vecs[i].cyc == 23) check("dec23", {29'd0, s_ch, s_op}, {29'd0, 3'd5, 2'd3});
            if (i == 29) begin
                check("adv_count_30", adv_cnt - adv_base, 30);
                check("sync_count_30", sync_cnt - sync_base, 1);
            end
        end

        // e1 and e2 in the same MCLK: new rq applies at that e2
        c1 = 1'b1; c2 = 1'b1; reset_fsm = 1'b1; tick();
        check("coinc_rq_cycle", {cycle, sync_frame, slot_adv}, {5'd0, 1'b0, 1'b1});
        reset_fsm = 1'b0; tick();
        check("coinc_rq_pulse_end", slot_adv, 0);
        c1 = 1'b0; c2 = 1'b0; tick(); tick();
        c1 = 1'b1; c2 = 1'b1; tick();
        check("coinc_norm_cycle", {cycle, slot_adv}, {5'd1, 1'b1});
        c1 = 1'b0; c2 = 1'b0; tick(); tick();

        // No c2 edges: outputs hold
        adv_base = adv_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("idle_hold_cycle", {cycle, ch, op}, {5'd1, 3'd1, 2'd0});
        check("idle_no_adv", adv_cnt - adv_base, 0);

        // Reset mid-frame with c2 held high: edge seen on first post-reset MCLK
        reset = 1'b1; c2 = 1'b1; tick();
        check("midrst_clear", {cycle, ch, op, sync_frame, slot_adv}, 0);
        tick();
        reset = 1'b0; tick();
        check("post_rst_edge", {cycle, slot_adv}, {5'd1, 1'b1});
        c2 = 1'b0; tick(); tick();

`ifdef YM3438_FSM_FRAME_CNT_EN
        run_period(1'b1, 1'b0);
        check("fcnt_clear0", frame_cnt, 0);
        for (int i = 0; i < 72; i++) run_period(1'b0, 1'b0);
        check("fcnt_three", frame_cnt, 3);
        run_period(1'b1, 1'b0);
        check("fcnt_rq_clear", frame_cnt, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
